simple_cpu: RTL and testbench



---
 rtl/simple_cpu_if.sv | 9 +
 rtl/simple_cpu.sv | 184 ++++++++++++++++++
 tb/tb_simple_cpu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/simple_cpu_if.sv
// PC exchange between the environment (holds the PC) and the datapath.
// The environment drives the current address and receives the next one.
interface simple_cpu_if;
  logic [31:0] Input_Addr;
  logic [31:0] Output_Addr;

  modport master (output Input_Addr, input Output_Addr);
  modport slave  (input Input_Addr, output Output_Addr);
endinterface

// File: rtl/simple_cpu.sv
// Single-cycle MIPS-subset datapath: combinational fetch/decode/next-PC,
// register file and data memory committed on the rising clock edge.

module instr_memory #(
  parameter int BYTES = 128,
  parameter int AW    = $clog2(BYTES)
) (
  input  logic          clk,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic [AW-3:0] word_addr,
  output logic [31:0]   instr
);
  logic [7:0] InstrMem [0:BYTES-1];

  // Byte load port; normally tied off because the environment preloads InstrMem.
  always_ff @(posedge clk) begin
    if (load_en) InstrMem[load_addr] <= load_data;
  end

  assign instr = {InstrMem[{word_addr, 2'd0}], InstrMem[{word_addr, 2'd1}],
                  InstrMem[{word_addr, 2'd2}], InstrMem[{word_addr, 2'd3}]};
endmodule

module register_file #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] R [0:NUM_REGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) R[i] <= '0;
    end else if (we && wa != 5'd0) begin
      R[wa] <= wd;
    end
  end

  assign rd_a = (ra == 5'd0) ? 32'd0 : R[ra];
  assign rd_b = (rb == 5'd0) ? 32'd0 : R[rb];
endmodule

module data_memory #(
  parameter int BYTES = 128,
  parameter int AW    = $clog2(BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-3:0] word_addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [7:0] DataMem [0:BYTES-1];

  // Contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      DataMem[{word_addr, 2'd0}] <= wdata[31:24];
      DataMem[{word_addr, 2'd1}] <= wdata[23:16];
      DataMem[{word_addr, 2'd2}] <= wdata[15:8];
      DataMem[{word_addr, 2'd3}] <= wdata[7:0];
    end
  end

  assign rdata = {DataMem[{word_addr, 2'd0}], DataMem[{word_addr, 2'd1}],
                  DataMem[{word_addr, 2'd2}], DataMem[{word_addr, 2'd3}]};
endmodule

module simple_cpu #(
  parameter int IM_BYTES = 128,
  parameter int DM_BYTES = 128,
  parameter int NUM_REGS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  simple_cpu_if.slave  bus
);
  localparam int IAW = $clog2(IM_BYTES);
  localparam int DAW = $clog2(DM_BYTES);

  logic [31:0]    instr;
  logic [31:0]    rs_val, rt_val, dm_rdata, imm_ext, pc4, br_target;
  logic [DAW-1:0] dm_addr;
  logic [5:0]     opcode, funct;
  logic [4:0]     rs, rt, rd, shamt;
  logic           reg_we, dm_we;
  logic [4:0]     wa;
  logic [31:0]    wd, next_pc;
  logic           unused_dm_low;

  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign imm_ext   = {{16{instr[15]}}, instr[15:0]};
  assign pc4       = bus.Input_Addr + 32'd4;
  assign br_target = pc4 + {imm_ext[29:0], 2'b00};
  // Only the in-range part of the effective address matters; byte offset is dropped.
  assign dm_addr       = rs_val[DAW-1:0] + imm_ext[DAW-1:0];
  assign unused_dm_low = ^dm_addr[1:0];

  instr_memory #(.BYTES(IM_BYTES)) Instr_Memory (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data (8'd0),
    .word_addr (bus.Input_Addr[IAW-1:2]),
    .instr     (instr)
  );

  register_file #(.NUM_REGS(NUM_REGS)) Register_File (
    .clk   (clk),
    .rst_n (rst_n),
    .ra    (rs),
    .rb    (rt),
    .rd_a  (rs_val),
    .rd_b  (rt_val),
    .we    (reg_we),
    .wa    (wa),
    .wd    (wd)
  );

  data_memory #(.BYTES(DM_BYTES)) Data_Memory (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (dm_we),
    .word_addr (dm_addr[DAW-1:2]),
    .wdata     (rt_val),
    .rdata     (dm_rdata)
  );

  always_comb begin
    next_pc = pc4;
    reg_we  = 1'b0;
    dm_we   = 1'b0;
    wa      = rd;
    wd      = 32'd0;
    case (opcode)
      6'h00: begin
        reg_we = 1'b1;
        case (funct)
          6'h21:   wd = rs_val + rt_val;
          6'h23:   wd = rs_val - rt_val;
          6'h24:   wd = rs_val & rt_val;
          6'h25:   wd = rs_val | rt_val;
          6'h2A:   wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h00:   wd = rt_val << shamt;
          6'h02:   wd = rt_val >> shamt;
          default: reg_we = 1'b0;
        endcase
      end
      6'h09: begin
        reg_we = 1'b1;
        wa     = rt;
        wd     = rs_val + imm_ext;
      end
      6'h23: begin
        reg_we = 1'b1;
        wa     = rt;
        wd     = dm_rdata;
      end
      6'h2B: dm_we = 1'b1;
      6'h04: if (rs_val == rt_val) next_pc = br_target;
      6'h05: if (rs_val != rt_val) next_pc = br_target;
      6'h02: next_pc = {pc4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  assign bus.Output_Addr = next_pc;
endmodule

// File: tb/tb_simple_cpu.sv
// Directed test of simple_cpu: expectations queued on stimulus, popped and
// asserted when the DUT produces the corresponding result.
module tb_simple_cpu;
  logic clk;
  logic rst_n;
  simple_cpu_if bus ();

  simple_cpu dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic put_instr(input int a, input logic [31:0] w);
    dut.Instr_Memory.InstrMem[a]   = w[31:24];
    dut.Instr_Memory.InstrMem[a+1] = w[23:16];
    dut.Instr_Memory.InstrMem[a+2] = w[15:8];
    dut.Instr_Memory.InstrMem[a+3] = w[7:0];
  endtask

  task automatic put_data(input int a, input logic [31:0] w);
    dut.Data_Memory.DataMem[a]   = w[31:24];
    dut.Data_Memory.DataMem[a+1] = w[23:16];
    dut.Data_Memory.DataMem[a+2] = w[15:8];
    dut.Data_Memory.DataMem[a+3] = w[7:0];
  endtask

  function automatic logic [31:0] dm_word(input int a);
    return {dut.Data_Memory.DataMem[a], dut.Data_Memory.DataMem[a+1],
            dut.Data_Memory.DataMem[a+2], dut.Data_Memory.DataMem[a+3]};
  endfunction

  function automatic logic [31:0] reg_word(input int i);
    return dut.Register_File.R[i];
  endfunction

  function automatic logic [31:0] reg_hash();
    logic [31:0] h;
    h = 32'd0;
    for (int i = 0; i < 32; i++) h = (h ^ dut.Register_File.R[i]) + 32'(i);
    return h;
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
      $display("check %-14s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  // kind: 0 next-PC only, 1 register idx, 2 data-memory word at idx, 3 register-file hash
  task automatic exec(input logic [31:0] pc, input logic [31:0] exp_next, input int kind,
                      input int idx, input logic [31:0] exp_val, input string tag);
    bus.Input_Addr = pc;
    push_exp({tag, "_next"}, exp_next);
    if (kind != 0) push_exp(tag, exp_val);
    #1;
    check_pop(bus.Output_Addr);
    @(posedge clk);
    #1;
    case (kind)
      1: check_pop(reg_word(idx));
      2: check_pop(dm_word(idx));
      3: check_pop(reg_hash());
      default: ;
    endcase
  endtask

  logic [31:0] h_before;

  initial begin
    rst_n = 1'b0;
    bus.Input_Addr = 32'd0;
    for (int i = 0; i < 128; i++) begin
      dut.Instr_Memory.InstrMem[i] = 8'd0;
      dut.Data_Memory.DataMem[i]   = 8'd0;
    end
    put_instr(32'h00, r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));      // addu $3,$1,$2
    put_instr(32'h04, r_ins(5'd1, 5'd2, 5'd4, 5'd0, 6'h23));      // subu $4,$1,$2
    put_instr(32'h08, i_ins(6'h04, 5'd1, 5'd1, 16'd3));           // beq $1,$1,+3
    put_instr(32'h0C, i_ins(6'h23, 5'd0, 5'd5, 16'h0010));        // lw $5,0x10($0)
    put_instr(32'h10, i_ins(6'h2B, 5'd0, 5'd5, 16'h0020));        // sw $5,0x20($0)
    put_instr(32'h14, i_ins(6'h05, 5'd1, 5'd1, 16'd5));           // bne equal
    put_instr(32'h18, i_ins(6'h05, 5'd1, 5'd2, 16'd1));           // bne unequal
    put_instr(32'h20, i_ins(6'h04, 5'd0, 5'd0, 16'hFFFE));        // beq -2
    put_instr(32'h24, i_ins(6'h09, 5'd0, 5'd0, 16'd7));           // addiu $0,$0,7
    put_instr(32'h28, r_ins(5'd7, 5'd8, 5'd6, 5'd0, 6'h2A));      // slt $6,$7,$8
    put_instr(32'h2C, 32'hFC000000);                              // unsupported
    put_instr(32'h30, i_ins(6'h2B, 5'd0, 5'd1, 16'h0030));        // sw $1,0x30($0)
    put_instr(32'h34, i_ins(6'h09, 5'd0, 5'd9, 16'hFFFF));        // addiu $9,$0,-1
    put_instr(32'h38, r_ins(5'd1, 5'd2, 5'd10, 5'd0, 6'h24));     // and
    put_instr(32'h3C, r_ins(5'd1, 5'd2, 5'd11, 5'd0, 6'h25));     // or
    put_instr(32'h40, {6'h02, 26'h000000F});                      // j 0xF
    put_instr(32'h44, r_ins(5'd0, 5'd1, 5'd12, 5'd4, 6'h00));     // sll $12,$1,4
    put_instr(32'h48, r_ins(5'd0, 5'd5, 5'd13, 5'd8, 6'h02));     // srl $13,$5,8
    put_instr(32'h4C, r_ins(5'd8, 5'd7, 5'd14, 5'd0, 6'h2A));     // slt $14,$8,$7
    put_data(32'h10, 32'hDEADBEEF);
    put_data(32'h30, 32'h11223344);

    repeat (2) @(posedge clk);
    #1;
    push_exp("reset_r3", 32'd0);
    check_pop(reg_word(3));
    push_exp("reset_next", 32'd4);
    check_pop(bus.Output_Addr);

    @(negedge clk);
    rst_n = 1'b1;
    dut.Register_File.R[1] = 32'd5;
    dut.Register_File.R[2] = 32'd3;
    dut.Register_File.R[7] = 32'hFFFFFFFF;
    dut.Register_File.R[8] = 32'd1;

    exec(32'h00, 32'h04, 1, 3,  32'd8,          "addu");
    exec(32'h04, 32'h08, 1, 4,  32'd2,          "subu");
    exec(32'h08, 32'h18, 0, 0,  32'd0,          "beq_fwd");
    exec(32'h0C, 32'h10, 1, 5,  32'hDEADBEEF,   "lw");
    exec(32'h10, 32'h14, 2, 32'h20, 32'hDEADBEEF, "sw");
    exec(32'h14, 32'h18, 0, 0,  32'd0,          "bne_eq");
    exec(32'h18, 32'h20, 0, 0,  32'd0,          "bne_ne");
    exec(32'h20, 32'h1C, 0, 0,  32'd0,          "beq_back");
    exec(32'h24, 32'h28, 1, 0,  32'd0,          "r0_write");
    exec(32'h28, 32'h2C, 1, 6,  32'd1,          "slt_neg");
    h_before = reg_hash();
    exec(32'h2C, 32'h30, 3, 0,  h_before,       "unsupported");
    exec(32'h34, 32'h38, 1, 9,  32'hFFFFFFFF,   "addiu_neg");
    exec(32'h38, 32'h3C, 1, 10, 32'd1,          "and");
    exec(32'h3C, 32'h40, 1, 11, 32'd7,          "or");
    exec(32'h40, 32'h3C, 0, 0,  32'd0,          "jump");
    exec(32'h44, 32'h48, 1, 12, 32'h50,         "sll");
    exec(32'h48, 32'h4C, 1, 13, 32'h00DEADBE,   "srl");
    exec(32'h4C, 32'h50, 1, 14, 32'd0,          "slt_pos");

    // Reset asserted mid-cycle while a sw is presented.
    bus.Input_Addr = 32'h30;
    push_exp("pre_rst_r1", 32'd5);
    #1;
    check_pop(reg_word(1));
    @(negedge clk);
    rst_n = 1'b0;
    push_exp("rst_r1_async", 32'd0);
    push_exp("rst_next", 32'h34);
    #1;
    check_pop(reg_word(1));
    check_pop(bus.Output_Addr);
    push_exp("rst_sw_blocked", 32'h11223344);
    @(posedge clk);
    #1;
    check_pop(dm_word(32'h30));

    @(negedge clk);
    rst_n = 1'b1;
    dut.Register_File.R[1] = 32'd9;
    dut.Register_File.R[2] = 32'd4;
    exec(32'h00, 32'h04, 1, 3, 32'd13, "post_rst_addu");

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
